ram_arbiter: RTL and testbench

- Shares the single-port 512-word RAM between two requesters: port 0 (CPU MAR/MDR path driven by the control unit) and port 1 (program loader / DMA engine).
- Sits between the requesters and RAM. Sequences each access as one grant, then RAM_LAT cycles with RAM controls held stable, then a one-cycle ack.
- Round-robin arbitration on simultaneous requests.

---
 rtl/ram_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_ram_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// -----------------------------------------------------------------------------
// ram_arbiter
//
// Shares one single-port RAM between two requesters. Port 0 is the CPU MAR/MDR
// path and port 1 is the program loader / DMA engine. Each access is one grant
// cycle, then RAM_LAT cycles with the RAM controls held from latched copies of
// the requester's we/addr/wdata, then a one-cycle ack. Simultaneous requests
// are resolved round-robin against the last port served.
//
// Optional build macro: RAM_ARB_LOCK_EN
//   When defined, adds lock0/lock1 inputs. A port that finishes an access with
//   its lock high keeps exclusive ownership of the RAM until it drops its lock
//   during an IDLE cycle.
//
// Ports
//   clock, reset        : rising-edge clock, asynchronous active-low reset
//   reqN, weN, addrN,
//   wdataN              : requester N level request and access attributes
//   ackN                : one-cycle completion pulse for requester N
//   rdataN              : last read data returned to requester N
//   lock0, lock1        : (RAM_ARB_LOCK_EN only) bus-lock requests
//   ram_enable, ram_read,
//   ram_write, ram_addr,
//   ram_wdata           : RAM controls, active only during ACCESS
//   ram_rdata           : RAM read data, captured on the last ACCESS cycle
//   busy                : high whenever the arbiter is not IDLE
//   grant_id            : port currently or most recently granted
// -----------------------------------------------------------------------------
module ram_arbiter #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int RAM_LAT    = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  ack0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata1,
`ifdef RAM_ARB_LOCK_EN
    input  logic                  lock0,
    input  logic                  lock1,
`endif
    output logic                  ram_enable,
    output logic                  ram_read,
    output logic                  ram_write,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  busy,
    output logic                  grant_id
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // cnt counts down the remaining ACCESS cycles; 4 bits covers RAM_LAT up to 15
    localparam logic [3:0] CNT_LOAD = 4'(RAM_LAT - 1);

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic                    we_l_q;
    logic [ADDR_WIDTH-1:0]   addr_l_q;
    logic [DATA_WIDTH-1:0]   wdata_l_q;
    logic                    grant_id_q;
    logic                    last_served_q;
    logic [DATA_WIDTH-1:0]   rdata0_q;
    logic [DATA_WIDTH-1:0]   rdata1_q;
    logic                    ack0_q;
    logic                    ack1_q;
    logic                    ram_enable_q;
    logic                    ram_read_q;
    logic                    ram_write_q;
    logic                    busy_q;
`ifdef RAM_ARB_LOCK_EN
    logic                    lock_valid_q;
    logic                    lock_owner_q;
    logic                    lock_hold_d;
`endif

    logic                    elig0_d;
    logic                    elig1_d;
    logic                    gnt_valid_d;
    logic                    gnt_port_d;
    logic                    sel_we_d;
    logic [ADDR_WIDTH-1:0]   sel_addr_d;
    logic [DATA_WIDTH-1:0]   sel_wdata_d;

    // Arbitration for the IDLE cycle
    always_comb begin
        elig0_d = req0;
        elig1_d = req1;
`ifdef RAM_ARB_LOCK_EN
        // An active lock whose owner still asserts it shuts out the other port;
        // once the owner's lock is low the lock is released and arbitration
        // this same cycle is ordinary round-robin.
        lock_hold_d = lock_valid_q && (lock_owner_q ? lock1 : lock0);
        if (lock_hold_d) begin
            elig0_d = req0 && !lock_owner_q;
            elig1_d = req1 &&  lock_owner_q;
        end
`endif
        gnt_valid_d = elig0_d | elig1_d;
        gnt_port_d  = (elig0_d && elig1_d) ? ~last_served_q : elig1_d;
        sel_we_d    = gnt_port_d ? we1    : we0;
        sel_addr_d  = gnt_port_d ? addr1  : addr0;
        sel_wdata_d = gnt_port_d ? wdata1 : wdata0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            we_l_q        <= 1'b0;
            addr_l_q      <= '0;
            wdata_l_q     <= '0;
            grant_id_q    <= 1'b0;
            last_served_q <= 1'b1;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            ram_enable_q  <= 1'b0;
            ram_read_q    <= 1'b0;
            ram_write_q   <= 1'b0;
            busy_q        <= 1'b0;
`ifdef RAM_ARB_LOCK_EN
            lock_valid_q  <= 1'b0;
            lock_owner_q  <= 1'b0;
`endif
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            case (state_q)
                IDLE: begin
`ifdef RAM_ARB_LOCK_EN
                    if (lock_valid_q && !lock_hold_d) begin
                        lock_valid_q <= 1'b0;
                    end
`endif
                    if (gnt_valid_d) begin
                        state_q      <= ACCESS;
                        cnt_q        <= CNT_LOAD;
                        grant_id_q   <= gnt_port_d;
                        we_l_q       <= sel_we_d;
                        addr_l_q     <= sel_addr_d;
                        wdata_l_q    <= sel_wdata_d;
                        ram_enable_q <= 1'b1;
                        ram_read_q   <= ~sel_we_d;
                        ram_write_q  <= sel_we_d;
                        busy_q       <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (cnt_q == 4'd0) begin
                        if (!we_l_q) begin
                            if (grant_id_q) begin
                                rdata1_q <= ram_rdata;
                            end else begin
                                rdata0_q <= ram_rdata;
                            end
                        end
                        ram_enable_q <= 1'b0;
                        ram_read_q   <= 1'b0;
                        ram_write_q  <= 1'b0;
                        ack0_q       <= ~grant_id_q;
                        ack1_q       <= grant_id_q;
                        state_q      <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
`ifdef RAM_ARB_LOCK_EN
                    if (grant_id_q ? lock1 : lock0) begin
                        lock_valid_q <= 1'b1;
                        lock_owner_q <= grant_id_q;
                    end
`endif
                    last_served_q <= grant_id_q;
                    busy_q        <= 1'b0;
                    state_q       <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack0       = ack0_q;
    assign ack1       = ack1_q;
    assign rdata0     = rdata0_q;
    assign rdata1     = rdata1_q;
    assign ram_enable = ram_enable_q;
    assign ram_read   = ram_read_q;
    assign ram_write  = ram_write_q;
    assign ram_addr   = addr_l_q;
    assign ram_wdata  = wdata_l_q;
    assign busy       = busy_q;
    assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_arbiter
//
// Two arbiter instances share one clock and reset: index 0 uses RAM_LAT=1,
// index 1 uses RAM_LAT=3. Each has its own behavioural RAM whose contents
// start as 32'hA000_0000 | address. Directed stimulus pushes the expected
// completions into a per-instance queue; the monitor pops one entry on each
// ack and compares the acking port and its read data.
// -----------------------------------------------------------------------------
module tb_ram_arbiter;

    logic clock;
    logic rst_n;
    logic mem_clr;

    logic        req0_s [2];
    logic        we0_s [2];
    logic [8:0]  addr0_s [2];
    logic [31:0] wdata0_s [2];
    logic        ack0_s [2];
    logic [31:0] rdata0_s [2];
    logic        req1_s [2];
    logic        we1_s [2];
    logic [8:0]  addr1_s [2];
    logic [31:0] wdata1_s [2];
    logic        ack1_s [2];
    logic [31:0] rdata1_s [2];
    logic        ram_en_s [2];
    logic        ram_rd_s [2];
    logic        ram_wr_s [2];
    logic [8:0]  ram_addr_s [2];
    logic [31:0] ram_wdata_s [2];
    logic [31:0] ram_rdata_s [2];
    logic        busy_s [2];
    logic        gid_s [2];
`ifdef RAM_ARB_LOCK_EN
    logic        lock0_s [2];
    logic        lock1_s [2];
`endif

    logic [31:0] mem [2][512];

    typedef struct packed {
        logic        port;
        logic [31:0] rdata;
    } exp_t;

    exp_t sbq0[$];
    exp_t sbq1[$];

    int n_checks = 0;
    int n_fail   = 0;
    int ack_cnt  = 0;

    ram_arbiter #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .RAM_LAT(1)) u_dut_l1 (
        .clock(clock), .reset(rst_n),
        .req0(req0_s[0]), .we0(we0_s[0]), .addr0(addr0_s[0]), .wdata0(wdata0_s[0]),
        .ack0(ack0_s[0]), .rdata0(rdata0_s[0]),
        .req1(req1_s[0]), .we1(we1_s[0]), .addr1(addr1_s[0]), .wdata1(wdata1_s[0]),
        .ack1(ack1_s[0]), .rdata1(rdata1_s[0]),
`ifdef RAM_ARB_LOCK_EN
        .lock0(lock0_s[0]), .lock1(lock1_s[0]),
`endif
        .ram_enable(ram_en_s[0]), .ram_read(ram_rd_s[0]), .ram_write(ram_wr_s[0]),
        .ram_addr(ram_addr_s[0]), .ram_wdata(ram_wdata_s[0]), .ram_rdata(ram_rdata_s[0]),
        .busy(busy_s[0]), .grant_id(gid_s[0])
    );

    ram_arbiter #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .RAM_LAT(3)) u_dut_l3 (
        .clock(clock), .reset(rst_n),
        .req0(req0_s[1]), .we0(we0_s[1]), .addr0(addr0_s[1]), .wdata0(wdata0_s[1]),
        .ack0(ack0_s[1]), .rdata0(rdata0_s[1]),
        .req1(req1_s[1]), .we1(we1_s[1]), .addr1(addr1_s[1]), .wdata1(wdata1_s[1]),
        .ack1(ack1_s[1]), .rdata1(rdata1_s[1]),
`ifdef RAM_ARB_LOCK_EN
        .lock0(lock0_s[1]), .lock1(lock1_s[1]),
`endif
        .ram_enable(ram_en_s[1]), .ram_read(ram_rd_s[1]), .ram_write(ram_wr_s[1]),
        .ram_addr(ram_addr_s[1]), .ram_wdata(ram_wdata_s[1]), .ram_rdata(ram_rdata_s[1]),
        .busy(busy_s[1]), .grant_id(gid_s[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural RAMs: combinational read, write on the rising edge
    always @(posedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_clr) begin
                for (int i = 0; i < 512; i++) mem[d][i] <= 32'hA000_0000 | 32'(i);
            end else if (ram_en_s[d] && ram_wr_s[d]) begin
                mem[d][ram_addr_s[d]] <= ram_wdata_s[d];
            end
        end
    end
    assign ram_rdata_s[0] = mem[0][ram_addr_s[0]];
    assign ram_rdata_s[1] = mem[1][ram_addr_s[1]];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void push(input int d, input logic p, input logic [31:0] rd);
        exp_t e;
        e.port  = p;
        e.rdata = rd;
        if (d == 0) sbq0.push_back(e);
        else        sbq1.push_back(e);
    endfunction

    task automatic mon_ack(input int d);
        exp_t e;
        logic p;
        p = ack1_s[d];
        ack_cnt++;
        check("ack_exclusive", 64'(ack0_s[d] & ack1_s[d]), 64'd0);
        if ((d == 0 && sbq0.size() == 0) || (d == 1 && sbq1.size() == 0)) begin
            check("unexpected_ack", 64'd1, 64'd0);
        end else begin
            e = (d == 0) ? sbq0.pop_front() : sbq1.pop_front();
            check("ack_port", 64'(p), 64'(e.port));
            check("ack_rdata", 64'(p ? rdata1_s[d] : rdata0_s[d]), 64'(e.rdata));
        end
    endtask

    // Monitor: scoreboard pop on ack, strobe containment every cycle it applies
    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (ack0_s[d] || ack1_s[d]) mon_ack(d);
            if (ram_en_s[d] || ram_rd_s[d] || ram_wr_s[d]) check("strobe_in_access", 64'(busy_s[d]), 64'd1);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Single-port access traced over n cycles; bit i of each trace is cycle i
    task automatic trace_one(input int d, input logic p, input logic we, input logic [8:0] a,
                             input logic [8:0] a_alt, input logic [31:0] wd, input int n,
                             output logic [15:0] en_t, output logic [15:0] rd_t,
                             output logic [15:0] wr_t, output logic [15:0] ack_t,
                             output logic addr_ok);
        logic acked;
        en_t = '0; rd_t = '0; wr_t = '0; ack_t = '0; addr_ok = 1'b1;
        if (!p) begin req0_s[d] = 1'b1; we0_s[d] = we; addr0_s[d] = a; wdata0_s[d] = wd; end
        else    begin req1_s[d] = 1'b1; we1_s[d] = we; addr1_s[d] = a; wdata1_s[d] = wd; end
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            en_t[i]  = ram_en_s[d];
            rd_t[i]  = ram_rd_s[d];
            wr_t[i]  = ram_wr_s[d];
            ack_t[i] = p ? ack1_s[d] : ack0_s[d];
            acked    = ack_t[i];
            if (ram_en_s[d] && (ram_addr_s[d] != a)) addr_ok = 1'b0;
            @(posedge clock);
            #1;
            if (i == 1) begin
                if (!p) addr0_s[d] = a_alt;
                else    addr1_s[d] = a_alt;
            end
            if (acked) begin
                if (!p) req0_s[d] = 1'b0;
                else    req1_s[d] = 1'b0;
            end
        end
        if (!p) req0_s[d] = 1'b0;
        else    req1_s[d] = 1'b0;
    endtask

    // Both ports request reads in the same cycle; each drops on its own ack
    task automatic trace_pair(input int d, input logic [8:0] a0, input logic [8:0] a1, input int n,
                              output logic [15:0] k0, output logic [15:0] k1);
        logic g0, g1;
        k0 = '0; k1 = '0;
        req0_s[d] = 1'b1; we0_s[d] = 1'b0; addr0_s[d] = a0;
        req1_s[d] = 1'b1; we1_s[d] = 1'b0; addr1_s[d] = a1;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            k0[i] = ack0_s[d];
            k1[i] = ack1_s[d];
            g0 = ack0_s[d];
            g1 = ack1_s[d];
            @(posedge clock);
            #1;
            if (g0) req0_s[d] = 1'b0;
            if (g1) req1_s[d] = 1'b0;
        end
        req0_s[d] = 1'b0;
        req1_s[d] = 1'b0;
    endtask

    initial begin
        logic [15:0] en_t, rd_t, wr_t, ack_t, k0, k1;
        logic        addr_ok, a1, g0;
        int          cnt_snap;

        rst_n   = 1'b0;
        mem_clr = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req0_s[d] = 1'b0; we0_s[d] = 1'b0; addr0_s[d] = '0; wdata0_s[d] = '0;
            req1_s[d] = 1'b0; we1_s[d] = 1'b0; addr1_s[d] = '0; wdata1_s[d] = '0;
`ifdef RAM_ARB_LOCK_EN
            lock0_s[d] = 1'b0; lock1_s[d] = 1'b0;
`endif
        end
        repeat (3) @(posedge clock);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_ack0", 64'(ack0_s[d]), 64'd0);
            check("rst_ack1", 64'(ack1_s[d]), 64'd0);
            check("rst_busy", 64'(busy_s[d]), 64'd0);
            check("rst_ram_enable", 64'(ram_en_s[d]), 64'd0);
            check("rst_grant_id", 64'(gid_s[d]), 64'd0);
            check("rst_rdata0", 64'(rdata0_s[d]), 64'd0);
        end
        @(negedge clock);
        rst_n   = 1'b1;
        mem_clr = 1'b0;
        tick();

        // Write then read back on port 0, RAM_LAT=1
        push(0, 1'b0, 32'h0000_0000);
        trace_one(0, 1'b0, 1'b1, 9'd5, 9'd5, 32'h0000_0069, 4, en_t, rd_t, wr_t, ack_t, addr_ok);
        check("t1_wr_trace", 64'(wr_t), 64'h0002);
        check("t1_en_trace", 64'(en_t), 64'h0002);
        check("t1_ack_trace", 64'(ack_t), 64'h0004);
        push(0, 1'b0, 32'h0000_0069);
        trace_one(0, 1'b0, 1'b0, 9'd5, 9'd5, 32'h0, 4, en_t, rd_t, wr_t, ack_t, addr_ok);
        check("t1_rd_trace", 64'(rd_t), 64'h0002);
        check("t1_rd_ack_trace", 64'(ack_t), 64'h0004);
        repeat (2) tick();
        check("t1_rdata0_hold", 64'(rdata0_s[0]), 64'h69);

        // Simultaneous read pairs on the RAM_LAT=3 instance, fresh from reset
        push(1, 1'b0, 32'hA000_000A);
        push(1, 1'b1, 32'hA000_0014);
        trace_pair(1, 9'd10, 9'd20, 11, k0, k1);
        check("t2_pair1_ack0", 64'(k0), 64'h0010);
        check("t2_pair1_ack1", 64'(k1), 64'h0200);
        push(1, 1'b0, 32'hA000_0003);
        push(1, 1'b1, 32'hA000_0004);
        trace_pair(1, 9'd3, 9'd4, 11, k0, k1);
        check("t2_pair2_ack0", 64'(k0), 64'h0010);
        check("t2_pair2_ack1", 64'(k1), 64'h0200);

        // RAM_LAT=3 read with addr0 changed mid-access
        push(1, 1'b0, 32'hA000_001E);
        trace_one(1, 1'b0, 1'b0, 9'd30, 9'd31, 32'h0, 6, en_t, rd_t, wr_t, ack_t, addr_ok);
        check("t3_rd_trace", 64'(rd_t), 64'h000E);
        check("t3_wr_trace", 64'(wr_t), 64'h0000);
        check("t3_ack_trace", 64'(ack_t), 64'h0010);
        check("t3_addr_stable", 64'(addr_ok), 64'd1);

        // Reset in the second ACCESS cycle of a RAM_LAT=3 read
        req0_s[1] = 1'b1; we0_s[1] = 1'b0; addr0_s[1] = 9'd40;
        tick();
        tick();
        check("t4_busy_pre", 64'(busy_s[1]), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_ram_enable", 64'(ram_en_s[1]), 64'd0);
        check("t4_ram_read", 64'(ram_rd_s[1]), 64'd0);
        check("t4_busy", 64'(busy_s[1]), 64'd0);
        check("t4_rdata0_cleared", 64'(rdata0_s[1]), 64'd0);
        req0_s[1] = 1'b0;
        cnt_snap  = ack_cnt;
        @(negedge clock);
        rst_n = 1'b1;
        repeat (8) tick();
        check("t4_no_ack", 64'(ack_cnt), 64'(cnt_snap));
        push(1, 1'b0, 32'hA000_0032);
        push(1, 1'b1, 32'hA000_0033);
        trace_pair(1, 9'd50, 9'd51, 11, k0, k1);
        check("t4_tie_ack0", 64'(k0), 64'h0010);
        check("t4_tie_ack1", 64'(k1), 64'h0200);

        // Port 0 holds req0 continuously, port 1 requests once
        push(0, 1'b0, 32'hA000_003C);
        push(0, 1'b1, 32'hA000_003D);
        push(0, 1'b0, 32'hA000_003C);
        push(0, 1'b0, 32'hA000_003C);
        req0_s[0] = 1'b1; we0_s[0] = 1'b0; addr0_s[0] = 9'd60;
        k1 = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            k1[i] = ack1_s[0];
            a1    = ack1_s[0];
            @(posedge clock);
            #1;
            if (i == 0) begin req1_s[0] = 1'b1; we1_s[0] = 1'b0; addr1_s[0] = 9'd61; end
            if (a1) req1_s[0] = 1'b0;
        end
        req0_s[0] = 1'b0;
        repeat (4) tick();
        check("t5_ack1_cycle", 64'(k1), 64'h0020);

`ifdef RAM_ARB_LOCK_EN
        // Port 1 locks across three accesses while req0 waits
        push(0, 1'b1, 32'hA000_0046);
        push(0, 1'b1, 32'hA000_0046);
        push(0, 1'b1, 32'hA000_0046);
        push(0, 1'b0, 32'hA000_0047);
        lock1_s[0] = 1'b1;
        req0_s[0] = 1'b1; we0_s[0] = 1'b0; addr0_s[0] = 9'd71;
        req1_s[0] = 1'b1; we1_s[0] = 1'b0; addr1_s[0] = 9'd70;
        k0 = '0; k1 = '0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clock);
            k0[i] = ack0_s[0];
            k1[i] = ack1_s[0];
            g0    = ack0_s[0];
            @(posedge clock);
            #1;
            if (i == 8) begin req1_s[0] = 1'b0; lock1_s[0] = 1'b0; end
            if (g0) req0_s[0] = 1'b0;
        end
        req0_s[0] = 1'b0;
        check("t6_lock_ack1", 64'(k1), 64'h0124);
        check("t6_lock_ack0", 64'(k0), 64'h0800);
`endif

        repeat (4) tick();
        check("sb0_empty", 64'(sbq0.size()), 64'd0);
        check("sb1_empty", 64'(sbq1.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
